pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register with valid/ready handshake, optional two-entry skid buffer, and synchronous flush. It replaces hand-written per-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB. Stage-specific fields are packed into a single payload vector by the instantiating stage. With SKID=1 it breaks the combinational ready path between adjacent stages; with SKID=0 it behaves as a classic stall/flush register.

## Interface
- WIDTH, 32: payload width in bits; must be >= 1.
- SKID, 1: 0 = single entry, ready passes combinationally; 1 = two entries, ready is registered.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  squash all held entries this cycle (branch/trap redirect).
- in_valid  in  1  upstream presents a valid payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage presents a valid payload (inverse of bubble).
- out_ready  in  1  downstream accepts this cycle (inverse of stall).
- out_data  out  WIDTH  payload presented downstream.
- occupancy  out  2  number of valid entries held (0..2; max 1 when SKID=0).

## Operation
- Accept: in_valid && in_ready at a rising edge. Release: out_valid && out_ready at a rising edge.
- Reset (rst_n=0 at the edge) has priority over everything else. Reset values: out_valid=0, out_data=0, occupancy=0, and all internal payload registers = 0.
  - Reset values of in_ready: SKID=1 → 1; SKID=0 → 1 (out_valid=0).
- Flush (rst_n=1, flush=1) clears every valid bit. Any accept in the same cycle is discarded, so occupancy becomes 0. Payload registers keep their values. in_ready is not gated by flush.
- SKID=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On accept, main ← in_data and out_valid ← 1.
  - On release without accept, out_valid ← 0.
- SKID=1 uses two entries, main (drives out_data) and skid, with states EMPTY, ONE and TWO. Registered in_ready = (state != TWO).
  - EMPTY + accept → ONE; main ← in_data.
  - ONE + accept + release → ONE; main ← in_data.
  - ONE + accept, no release → TWO; skid ← in_data.
  - ONE + release, no accept → EMPTY.
  - TWO + release → ONE; main ← skid. No accept is possible in TWO.
  - Any other combination leaves the state unchanged.
- out_valid = (state != EMPTY). occupancy = 0, 1 or 2 for EMPTY, ONE or TWO.
- Ordering is strictly FIFO. No payload is ever duplicated or dropped except by flush or reset.
- out_data is stable while out_valid && !out_ready. Its value is don't-care when out_valid=0; the bench must not check it then.

## Timing
- Latency: an accept at edge N gives out_valid=1 with that data after edge N, i.e. in cycle N+1.
- Throughput: 1 payload/cycle sustained when out_ready is held at 1, for both SKID values.
- SKID=1: in_ready and out_valid are pure register outputs, with no combinational path from any input.
- SKID=0: the only combinational path is out_ready → in_ready.
- Flush asserted at edge N: out_valid=0 and occupancy=0 in cycle N+1. With SKID=1, in_ready=1 in cycle N+1.
- Reset mid-operation: all held payloads are lost. After the reset edge the outputs take their reset values regardless of flush, in_valid or out_ready.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF, then release → out_valid=0, occupancy=0, in_ready=1, out_data=0.
- **Streaming:** SKID=1, out_ready=1, push 0x1..0x8 back-to-back → out_data shows 0x1..0x8 on consecutive cycles starting 1 cycle after the first accept; in_ready stays 1 throughout.
- **Stall:** SKID=1, out_ready=0, push 0xA then 0xB → occupancy=2 and in_ready=0. Then 0xC is held off. Raise out_ready → outputs are 0xA, 0xB, 0xC in order, with no loss and no duplicates.
- **Flush in TWO:** SKID=1, state TWO holding 0xA/0xB, flush=1 together with in_valid=1 and in_data=0xC → next cycle out_valid=0, occupancy=0; 0xC never appears.
- **SKID=0 stall:** out_valid=1 with 0x5 and out_ready=0 → in_ready=0 combinationally. Toggling out_ready to 1 in the same cycle → in_ready=1; 0x6 is accepted and presented next cycle.
- **Randomized cross-check:** random in_valid/out_ready/flush for 10k cycles, both SKID values, WIDTH=1 and WIDTH=128 → output sequence matches a reference FIFO model flushed on flush; occupancy never exceeds 2 (or 1 for SKID=0).

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream accept side
// (in_*) and downstream release side (out_*).
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Environment side: drives the payload in and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Stage side: the register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, synchronous
// flush and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
  parameter int unsigned WIDTH = 32,
  parameter bit          SKID  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  pipe_stage_reg_if.slave     bus,
  output logic [1:0]          occupancy
);

  if (SKID) begin : g_skid
    typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             rel;

    assign accept = bus.in_valid && in_ready_q;
    assign rel    = out_valid_q && bus.out_ready;

    // State and payload registers; in_ready/out_valid are flopped from the
    // next state so neither has a combinational path from any input.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q     <= EMPTY;
        main_q      <= '0;
        skid_q      <= '0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        main_q      <= main_d;
        skid_q      <= skid_d;
        in_ready_q  <= (state_d != TWO);
        out_valid_q <= (state_d != EMPTY);
      end
    end

    // Next-state and payload steering; flush empties the buffer but leaves
    // the payload registers untouched.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = bus.in_data;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_d = bus.in_data;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = bus.in_data;
          end else if (rel) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (rel) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
      if (flush) begin
        state_d = EMPTY;
        main_d  = main_q;
        skid_d  = skid_q;
      end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;
  end else begin : g_noskid
    logic             valid_q;
    logic [WIDTH-1:0] main_q;
    logic             accept;
    logic             rel;

    assign bus.in_ready = bus.out_ready || !valid_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign rel          = valid_q && bus.out_ready;

    // Classic stall/flush register: load on accept, drop valid on release.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        main_q  <= bus.in_data;
      end else if (rel) begin
        valid_q <= 1'b0;
      end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_data  = main_q;
    assign occupancy     = {1'b0, valid_q};
  end

endmodule
